// File: rtl/fft32_stage_sequencer.sv
// Control FSM for the 32-point iterative radix-2 FFT: load, NUM_STAGES butterfly passes, output.
// Define FFT32_SEQ_PERF_EN to add saturating frame/stall performance counters.
module fft32_stage_sequencer #(
  parameter int NUM_STAGES    = 5,
  parameter int STAGE_LATENCY = 2,
  parameter int SEL_W         = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             load_en,
  output logic [SEL_W-1:0] stage_sel,
  output logic             stage_en,
  output logic             first_stage,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready
`ifdef FFT32_SEQ_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [15:0]      perf_frames,
  output logic [15:0]      perf_stall
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_OUT
  } state_t;

  localparam logic [3:0]       LAT_MAX  = 4'(STAGE_LATENCY - 1);
  localparam logic [SEL_W-1:0] LAST_STG = SEL_W'(NUM_STAGES - 1);

  state_t           r_state;
  state_t           w_next;
  logic [SEL_W-1:0] r_stage;
  logic [3:0]       r_lat;
  logic             w_tick;
  logic             w_last_stg;
  logic             w_accept;

  assign w_tick     = (r_state == S_RUN) && (r_lat == LAT_MAX);
  assign w_last_stg = (r_stage == LAST_STG);
  assign w_accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) w_next = S_RUN;
      S_RUN: if (w_tick && w_last_stg) w_next = S_OUT;
      S_OUT: if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Stage index advances once per settled butterfly pass.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      r_stage <= '0;
      r_lat   <= '0;
    end else if (r_state == S_RUN) begin
      if (w_tick) begin
        r_lat   <= '0;
        r_stage <= w_last_stg ? '0 : r_stage + SEL_W'(1);
      end else begin
        r_lat <= r_lat + 4'd1;
      end
    end else begin
      r_stage <= '0;
      r_lat   <= '0;
    end
  end

  always_comb begin
    in_ready    = (r_state == S_IDLE) && rst_n && !clear;
    load_en     = in_valid && in_ready;
    stage_sel   = r_stage;
    stage_en    = w_tick && rst_n && !clear;
    first_stage = (r_state == S_RUN) && (r_stage == '0);
    busy        = (r_state != S_IDLE);
    out_valid   = (r_state == S_OUT);
  end

`ifdef FFT32_SEQ_PERF_EN
  logic [15:0] r_frames;
  logic [15:0] r_stall;

  always_ff @(posedge clk) begin
    if (!rst_n || perf_clr) begin
      r_frames <= '0;
      r_stall  <= '0;
    end else begin
      if (out_valid && out_ready && r_frames != 16'hFFFF)
        r_frames <= r_frames + 16'd1;
      if (out_valid && !out_ready && r_stall != 16'hFFFF)
        r_stall <= r_stall + 16'd1;
    end
  end

  assign perf_frames = r_frames;
  assign perf_stall  = r_stall;
`endif

endmodule

// File: tb/tb_fft32_stage_sequencer.sv
// Randomized + directed bench for fft32_stage_sequencer against a cycle-offset model.
// Directed sections pin the model with literal cycle numbers for the default build.
module tb_fft32_stage_sequencer;

  localparam int NS = 5;
  localparam int L  = 2;
  localparam int SW = 3;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          clear = 0;
  logic          in_valid = 0;
  logic          out_ready = 1;
  logic          in_ready;
  logic          load_en;
  logic [SW-1:0] stage_sel;
  logic          stage_en;
  logic          first_stage;
  logic          busy;
  logic          out_valid;
`ifdef FFT32_SEQ_PERF_EN
  logic          perf_clr = 0;
  logic [15:0]   perf_frames;
  logic [15:0]   perf_stall;
`endif

  fft32_stage_sequencer #(
    .NUM_STAGES(NS), .STAGE_LATENCY(L), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready),
    .load_en(load_en), .stage_sel(stage_sel),
    .stage_en(stage_en), .first_stage(first_stage),
    .busy(busy), .out_valid(out_valid),
    .out_ready(out_ready)
`ifdef FFT32_SEQ_PERF_EN
    , .perf_clr(perf_clr),
    .perf_frames(perf_frames), .perf_stall(perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_en = 0;

  // Model: mode 0 idle, 1 running, 2 output; m_k = cycles spent running.
  int m_mode = 0;
  int m_k = 0;
  int m_pf = 0;
  int m_ps = 0;

  int q_load[$];
  int q_en[$];
  int q_ov[$];
  int q_fs[$];
  int q_irise[$];
  bit prev_ir = 0;

  task automatic chk(input string nm, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i, input int b);
    if (i < q.size()) return q[i] - b;
    return -1;
  endfunction

  task automatic clr_logs();
    q_load.delete();
    q_en.delete();
    q_ov.delete();
    q_fs.delete();
    q_irise.delete();
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    int e_stage, e_en, e_ir, e_ov;
    if (chk_en) begin
      e_stage = (m_mode == 1) ? m_k / L : 0;
      e_en = (m_mode == 1 && (m_k % L) == L - 1 && rst_n && !clear) ? 1 : 0;
      e_ir = (m_mode == 0 && rst_n && !clear) ? 1 : 0;
      e_ov = (m_mode == 2) ? 1 : 0;
      chk("in_ready", in_ready, e_ir);
      chk("load_en", load_en, e_ir & in_valid);
      chk("stage_sel", stage_sel, e_stage);
      chk("stage_en", stage_en, e_en);
      chk("first_stage", first_stage, (m_mode == 1 && e_stage == 0) ? 1 : 0);
      chk("busy", busy, (m_mode != 0) ? 1 : 0);
      chk("out_valid", out_valid, e_ov);
`ifdef FFT32_SEQ_PERF_EN
      chk("perf_frames", perf_frames, m_pf);
      chk("perf_stall", perf_stall, m_ps);
      if (!rst_n || perf_clr) begin
        m_pf = 0;
        m_ps = 0;
      end else begin
        if (e_ov && out_ready && m_pf < 65535) m_pf++;
        if (e_ov && !out_ready && m_ps < 65535) m_ps++;
      end
`endif
      if (load_en) q_load.push_back(cyc);
      if (stage_en) q_en.push_back(cyc);
      if (out_valid) q_ov.push_back(cyc);
      if (first_stage) q_fs.push_back(cyc);
      if (in_ready && !prev_ir) q_irise.push_back(cyc);
      prev_ir = in_ready;
      if (!rst_n || clear) begin
        m_mode = 0;
        m_k = 0;
      end else begin
        case (m_mode)
          0: if (in_valid) begin m_mode = 1; m_k = 0; end
          1: if (m_k == NS * L - 1) m_mode = 2; else m_k++;
          default: if (out_ready) m_mode = 0;
        endcase
      end
    end
  end

  int b;

  initial begin
    rst_n = 0;
    in_valid = 1;
    @(posedge clk);
    #1;
    chk_en = 1;
    step(2);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_load_en", load_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    rst_n = 1;
    in_valid = 0;
    #1;
    chk("rel_in_ready", in_ready, 1);
    step(1);

    clr_logs();
    b = cyc;
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(14);
    chk("sf_load_cyc", at(q_load, 0, b), 0);
    chk("sf_en_cnt", q_en.size(), 5);
    for (int i = 0; i < 5; i++) chk("sf_en_cyc", at(q_en, i, b), 2 + 2 * i);
    chk("sf_fs_cnt", q_fs.size(), 2);
    chk("sf_fs_first", at(q_fs, 0, b), 1);
    chk("sf_ov_cnt", q_ov.size(), 1);
    chk("sf_ov_cyc", at(q_ov, 0, b), 11);
    chk("sf_ready_cyc", at(q_irise, 0, b), 12);

`ifdef FFT32_SEQ_PERF_EN
    perf_clr = 1;
    step(1);
    perf_clr = 0;
`endif
    clr_logs();
    b = cyc;
    in_valid = 1;
    out_ready = 0;
    step(1);
    in_valid = 0;
    step(17);
    out_ready = 1;
    step(3);
    chk("bp_ov_cnt", q_ov.size(), 8);
    chk("bp_ov_cyc", at(q_ov, 0, b), 11);
    chk("bp_en_cnt", q_en.size(), 5);
    chk("bp_ready_cyc", at(q_irise, 0, b), 19);
`ifdef FFT32_SEQ_PERF_EN
    chk("bp_perf_stall", perf_stall, 7);
    chk("bp_perf_frames", perf_frames, 1);
`endif

    clr_logs();
    b = cyc;
    in_valid = 1;
    out_ready = 1;
    step(48);
    in_valid = 0;
    step(2);
    chk("b2b_load_cnt", q_load.size(), 4);
    for (int i = 0; i < 4; i++) chk("b2b_load_cyc", at(q_load, i, b), 12 * i);
    chk("b2b_en_cnt", q_en.size(), 20);

    clr_logs();
    b = cyc;
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(4);
    clear = 1;
    step(1);
    clear = 0;
    chk("ab_en_cnt", q_en.size(), 2);
    chk("ab_busy", busy, 0);
    in_valid = 1;
    step(1);
    in_valid = 0;
    step(14);
    chk("ab_load_cyc", at(q_load, 1, b), 6);
    chk("ab_ov_cnt", q_ov.size(), 1);
    chk("ab_ov_cyc", at(q_ov, 0, b), 17);
    chk("ab_en_total", q_en.size(), 7);

    repeat (3000) begin
      in_valid  = ($urandom_range(0, 99) < 60);
      out_ready = ($urandom_range(0, 99) < 70);
      clear     = ($urandom_range(0, 99) < 2);
      rst_n     = !($urandom_range(0, 199) < 1);
`ifdef FFT32_SEQ_PERF_EN
      perf_clr  = ($urandom_range(0, 199) < 1);
`endif
      step(1);
    end
    in_valid = 0;
    out_ready = 1;
    clear = 0;
    rst_n = 1;
`ifdef FFT32_SEQ_PERF_EN
    perf_clr = 0;
`endif
    step(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
